// File: rtl/sprite_pkg.sv
// Shared types and constants for the 64x64 sprite line scheduling path.
package sprite_pkg;

  localparam int SPRITE_SIZE  = 64;
  localparam int SPRITE_ROW_W = 6;
  localparam int SCR_W        = 10;
  localparam int ID_W         = 4;

  // One renderer slot: where the sprite starts, which row of it to draw, and who it is.
  typedef struct packed {
    logic [SCR_W-1:0]        x;
    logic [SPRITE_ROW_W-1:0] row;
    logic [ID_W-1:0]         id;
  } slot_t;

  // One sprite table entry (21 bits).
  typedef struct packed {
    logic [SCR_W-1:0] x;
    logic [SCR_W-1:0] y;
    logic             enable;
  } sprite_entry_t;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  // Vertical overlap test in 11-bit zero-extended arithmetic so that sprites
  // near the bottom of the coordinate space never wrap back to the top.
  function automatic logic sprite_hit(input logic [SCR_W-1:0] line_y,
                                      input logic [SCR_W-1:0] sprite_y);
    logic [SCR_W:0] diff;
    diff = {1'b0, line_y} - {1'b0, sprite_y};
    return (line_y >= sprite_y) && (diff < (SCR_W+1)'(SPRITE_SIZE));
  endfunction

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Bus between the scanline timing / CPU side and the sprite line scheduler.
interface sprite_line_scheduler_if #(
  parameter int SLOTS = 4,
  parameter int IDX_W = 4
);

  logic                                       line_start;
  logic [sprite_pkg::SCR_W-1:0]               next_y;
  logic                                       wr_en;
  logic [IDX_W-1:0]                           wr_idx;
  logic [sprite_pkg::SCR_W-1:0]               wr_x;
  logic [sprite_pkg::SCR_W-1:0]               wr_y;
  logic                                       wr_enable;
  logic [SLOTS-1:0]                           slot_valid;
  logic [SLOTS*sprite_pkg::SCR_W-1:0]         slot_x;
  logic [SLOTS*sprite_pkg::SPRITE_ROW_W-1:0]  slot_row;
  logic [SLOTS*IDX_W-1:0]                     slot_id;
  logic                                       overflow;
  logic                                       busy;
  logic                                       done;

  modport master (
    output line_start, next_y, wr_en, wr_idx, wr_x, wr_y, wr_enable,
    input  slot_valid, slot_x, slot_row, slot_id, overflow, busy, done
  );

  modport slave (
    input  line_start, next_y, wr_en, wr_idx, wr_x, wr_y, wr_enable,
    output slot_valid, slot_x, slot_row, slot_id, overflow, busy, done
  );

endinterface

// File: rtl/sprite_table.sv
// Sprite attribute register file: one synchronous write port, one combinational
// read port. A same-index read during a write sees the old contents.
module sprite_table
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int IDX_W       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  sprite_entry_t wr_entry,
  input  logic [IDX_W-1:0] rd_idx,
  output sprite_entry_t rd_entry
);

  sprite_entry_t mem [NUM_SPRITES];

  // Reset wipes every entry (so all sprites come up disabled); writes never stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the sprite table during hblank and
// loads the first SLOTS sprites overlapping the next line into renderer slots.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int SLOTS       = 4,
  parameter int IDX_W       = 4
) (
  input logic                    clk,
  input logic                    reset,
  sprite_line_scheduler_if.slave bus
);

  localparam int CNT_W      = $clog2(SLOTS + 1);
  localparam int SLOT_SEL_W = $clog2(SLOTS);

  state_t           state;
  logic [SCR_W-1:0] line_y;
  logic [SCR_W-1:0] pend_y;
  logic             pend_req;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic             pend_ovf;
  slot_t            pending [SLOTS];
  slot_t            slots   [SLOTS];
  logic [SLOTS-1:0] slot_valid_q;
  logic             overflow_q;
  logic             busy_q;
  logic             done_q;

  sprite_entry_t    wr_entry;
  sprite_entry_t    rd_entry;
  logic             hit;
  logic [SCR_W:0]   row_diff;

  assign wr_entry = '{x: bus.wr_x, y: bus.wr_y, enable: bus.wr_enable};

  sprite_table #(
    .NUM_SPRITES (NUM_SPRITES),
    .IDX_W       (IDX_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_idx   (bus.wr_idx),
    .wr_entry (wr_entry),
    .rd_idx   (idx),
    .rd_entry (rd_entry)
  );

  assign row_diff = {1'b0, line_y} - {1'b0, rd_entry.y};
  assign hit      = rd_entry.enable && sprite_hit(line_y, rd_entry.y);

  // Scheduler FSM: IDLE waits for a line request, SCAN walks the table one
  // entry per cycle, COMMIT publishes the pending slots in a single cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      line_y       <= '0;
      pend_y       <= '0;
      pend_req     <= 1'b0;
      idx          <= '0;
      count        <= '0;
      pend_ovf     <= 1'b0;
      slot_valid_q <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        pending[k] <= '0;
        slots[k]   <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.line_start || pend_req) begin
            line_y   <= bus.line_start ? bus.next_y : pend_y;
            pend_req <= 1'b0;
            idx      <= '0;
            count    <= '0;
            pend_ovf <= 1'b0;
            busy_q   <= 1'b1;
            state    <= SCAN;
            for (int k = 0; k < SLOTS; k++) begin
              pending[k] <= '0;
            end
          end
        end

        SCAN: begin
          if (bus.line_start) begin
            line_y   <= bus.next_y;
            idx      <= '0;
            count    <= '0;
            pend_ovf <= 1'b0;
            for (int k = 0; k < SLOTS; k++) begin
              pending[k] <= '0;
            end
          end else begin
            if (hit) begin
              if (count < CNT_W'(SLOTS)) begin
                pending[count[SLOT_SEL_W-1:0]] <= '{x:   rd_entry.x,
                                                    row: row_diff[SPRITE_ROW_W-1:0],
                                                    id:  ID_W'(idx)};
                count <= count + 1'b1;
              end else begin
                pend_ovf <= 1'b1;
              end
            end
            if (idx == IDX_W'(NUM_SPRITES - 1)) begin
              state  <= COMMIT;
              done_q <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        COMMIT: begin
          for (int k = 0; k < SLOTS; k++) begin
            slots[k]        <= pending[k];
            slot_valid_q[k] <= (CNT_W'(k) < count);
          end
          overflow_q <= pend_ovf;
          busy_q     <= 1'b0;
          state      <= IDLE;
          if (bus.line_start) begin
            pend_req <= 1'b1;
            pend_y   <= bus.next_y;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < SLOTS; k++) begin : g_slot_out
    assign bus.slot_x[k*SCR_W +: SCR_W]               = slots[k].x;
    assign bus.slot_row[k*SPRITE_ROW_W +: SPRITE_ROW_W] = slots[k].row;
    assign bus.slot_id[k*IDX_W +: IDX_W]              = IDX_W'(slots[k].id);
  end

  assign bus.slot_valid = slot_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite scheduler for the 64x64 3-bit colour sprite path.
- During horizontal blanking it scans a table of NUM_SPRITES sprite entries and finds those that overlap the next visible line.
- It loads up to SLOTS of them into line slots (x position, row within sprite, sprite id), which feed a fixed bank of sprite renderers.
- It also reports when a line holds more overlapping sprites than there are slots.

Parameters:
- NUM_SPRITES, 16, number of sprite table entries (power of 2, ≥ 2).
- SLOTS, 4, number of renderer slots filled per line.
- SPRITE_SIZE, 64, sprite height and width in pixels (power of 2).
- IDX_W, 4, log2(NUM_SPRITES).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high reset.
- line_start  in  1  one-cycle pulse at the start of hblank; requests a scan for next_y.
- next_y  in  10  scanline to be scheduled; sampled on line_start.
- wr_en  in  1  sprite table write strobe.
- wr_idx  in  IDX_W  table entry to write.
- wr_x  in  10  sprite top-left x.
- wr_y  in  10  sprite top-left y.
- wr_enable  in  1  entry enable bit.
- slot_valid  out  SLOTS  per-slot valid.
- slot_x  out  SLOTS*10  per-slot sprite x; slot k occupies bits [10k+9:10k].
- slot_row  out  SLOTS*6  per-slot row inside the sprite (next_y - sprite_y).
- slot_id  out  SLOTS*IDX_W  per-slot table index.
- overflow  out  1  more than SLOTS sprites hit the last committed line.
- busy  out  1  a scan is in progress.
- done  out  1  one-cycle pulse when slot outputs update.

Behaviour:
- **Reset (async):**
  - All table entries cleared, with enable=0.
  - All slot outputs 0, overflow=0, busy=0, done=0.
  - State IDLE, pending buffer cleared.
- **States:** IDLE, SCAN, COMMIT.
- **IDLE:**
  - On line_start: latch next_y into line_y, idx=0, pending count=0, pending overflow=0.
  - Clear the pending buffer, then go to SCAN. busy=1 from the next cycle.
- **SCAN (one entry per cycle, ascending idx):**
  - Hit condition: enable=1 AND line_y ≥ y AND (line_y − y) < SPRITE_SIZE.
  - The compare uses 11-bit zero-extended arithmetic, so sprites with y+SPRITE_SIZE > 1023 do not wrap.
  - On a hit with count < SLOTS: pending[count] = {x, (line_y−y)[5:0], idx}, and count increments.
  - On a hit with count == SLOTS: set pending overflow; the entry is dropped.
  - After idx == NUM_SPRITES−1, go to COMMIT.
- **COMMIT (1 cycle):**
  - Copy the pending buffer to the slot outputs atomically.
  - slot_valid bit k = (k < count).
  - overflow = pending overflow. done=1 for that cycle. Return to IDLE with busy=0.
- **Priority:** lower table index gets the lower slot number. Slot 0 is the highest-priority sprite and the top drawing layer.
- **Latency:**
  - line_start at cycle T → SCAN covers T+1..T+NUM_SPRITES → COMMIT and done at T+NUM_SPRITES+1.
  - Slot outputs change at T+NUM_SPRITES+2 and stay stable until the next commit.
- **line_start during SCAN:** restart the scan. Re-latch next_y, idx=0, and discard the pending buffer. Slot outputs are unchanged.
- **line_start during COMMIT:** the commit completes, and the new scan starts in the following cycle. The pulse must not be lost; hold a one-cycle pending request for it.
- **Table writes:**
  - Accepted in any state, taking effect on the next clock edge.
  - A read of the same index in the same cycle returns the old value.
  - Writes never stall.
- **Zero sprites enabled:** commit gives slot_valid=0 and overflow=0.

Decomposition:
- **Shared package (sprite_pkg):**
  - SPRITE_SIZE and SPRITE_ROW_W=6.
  - SCR_W=10 for screen coordinate width.
  - A slot struct {x[9:0], row[5:0], id}.
  - A sprite entry struct {x, y, enable}.
  - State enum {IDLE, SCAN, COMMIT}.
- **Sub-module sprite_table:**
  - NUM_SPRITES×21-bit register file.
  - One synchronous write port and one combinational read port.
  - Async reset clears all enables.

Test Plan:
1. Reset, write entry 2 {x=100, y=50, en=1}, line_start with next_y=60 → done at cycle 17; slot_valid=4'b0001, slot_x[0]=100, slot_row[0]=10, slot_id[0]=2, overflow=0.
2. Boundary rows with entry 2 {y=50}: next_y=49 → slot_valid=0; next_y=113 → row=63 valid; next_y=114 → slot_valid=0. Separately, an entry with y=1000, next_y=5 → no hit (no wrap).
3. Six enabled entries 0..5, all y=0, next_y=0 → slot_id 0,1,2,3 in slots 0..3; slot_valid=4'b1111; overflow=1. A next line with two hits → overflow=0, slot_valid=4'b0011.
4. Disabled entry with y=0, next_y=0 → not scheduled; slot_valid=0.
5. line_start at T, second line_start (next_y=200) at T+5 → done only at T+5+17; slots reflect y=200; slot outputs unchanged between T and the commit.
6. Assert reset mid-SCAN (cycle T+8) → slot outputs, busy and done go 0 immediately; the table is cleared, so a subsequent scan yields slot_valid=0.
